// File: rtl/zone_pkg.sv
// Shared constants, FSM encoding and zone-index helper for the red-target zone detector.
package zone_pkg;
  localparam int NUM_ZONES      = 8;
  localparam int ZONE_COLS      = 4;
  localparam int ZONE_ROWS      = 2;
  localparam int ZONE_W         = 3;
  localparam int CNT_W_DEF      = 20;
  localparam int H_ACTIVE_DEF   = 1280;
  localparam int V_ACTIVE_DEF   = 720;
  localparam int MIN_PIXELS_DEF = 2000;

  localparam logic [7:0] R_MIN_DEF  = 8'd150;
  localparam logic [7:0] GB_MAX_DEF = 8'd80;

  typedef enum logic [1:0] {
    ACCUM = 2'b00,
    SNAP  = 2'b01,
    SCAN  = 2'b10
  } state_t;

  function automatic logic [ZONE_W-1:0] zone_index(input logic row, input logic [1:0] col);
    return {row, col};
  endfunction
endpackage

// File: rtl/zone_detector_if.sv
// Video-in / zone-report bundle between the HDMI pixel source and the zone detector.
interface zone_detector_if #(parameter int CNT_W = zone_pkg::CNT_W_DEF);
  logic             de;
  logic             vs;
  logic [7:0]       pix_r;
  logic [7:0]       pix_g;
  logic [7:0]       pix_b;
  logic             mask;
  logic [2:0]       zone;
  logic             target_found;
  logic             zone_valid;
  logic [CNT_W-1:0] pix_count;

  modport master (
    output de, vs, pix_r, pix_g, pix_b,
    input  mask, zone, target_found, zone_valid, pix_count
  );

  modport slave (
    input  de, vs, pix_r, pix_g, pix_b,
    output mask, zone, target_found, zone_valid, pix_count
  );
endinterface

// File: rtl/zone_pixel_classifier.sv
// Per-pixel red test: combinational match for the counters, one-cycle registered copy for the overlay.
module zone_pixel_classifier #(
  parameter logic [7:0] R_MIN  = zone_pkg::R_MIN_DEF,
  parameter logic [7:0] GB_MAX = zone_pkg::GB_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       de,
  input  logic [7:0] pix_r,
  input  logic [7:0] pix_g,
  input  logic [7:0] pix_b,
  output logic       match,
  output logic       mask
);
  assign match = de && (pix_r > R_MIN) && (pix_g < GB_MAX) && (pix_b < GB_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mask <= 1'b0;
    else     mask <= match;
  end
endmodule

// File: rtl/zone_detector.sv
// Counts red pixels per 4x2 screen zone and reports the busiest zone once per frame,
// 10 cycles after the frame-start edge.
module zone_detector
  import zone_pkg::*;
#(
  parameter int         H_ACTIVE   = H_ACTIVE_DEF,
  parameter int         V_ACTIVE   = V_ACTIVE_DEF,
  parameter logic [7:0] R_MIN      = R_MIN_DEF,
  parameter logic [7:0] GB_MAX     = GB_MAX_DEF,
  parameter int         MIN_PIXELS = MIN_PIXELS_DEF,
  parameter int         CNT_W      = CNT_W_DEF,
  parameter bit         VS_POL     = 1'b1
) (
  input  logic      hdmi_clk1x_i,
  input  logic      rst_i,
  zone_detector_if.slave bus
);
  localparam int PW = 16;
  localparam logic [PW-1:0]    H_LIM   = PW'(H_ACTIVE);
  localparam logic [PW-1:0]    V_LIM   = PW'(V_ACTIVE);
  localparam logic [PW-1:0]    COL1    = PW'(H_ACTIVE / ZONE_COLS);
  localparam logic [PW-1:0]    COL2    = PW'(2 * (H_ACTIVE / ZONE_COLS));
  localparam logic [PW-1:0]    COL3    = PW'(3 * (H_ACTIVE / ZONE_COLS));
  localparam logic [PW-1:0]    ROW1    = PW'(V_ACTIVE / ZONE_ROWS);
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIXELS);
  localparam logic [ZONE_W-1:0] LAST_IDX = ZONE_W'(NUM_ZONES - 1);

  logic              clk;
  logic              rst;
  logic              match;
  logic              de_d;
  logic              vs_d;
  logic [PW-1:0]     x_q;
  logic [PW-1:0]     y_q;
  logic              frame_start;
  logic              line_end;
  logic              in_range;
  logic              hit;
  logic [1:0]        col;
  logic              row;
  logic [ZONE_W-1:0] pix_zone;

  logic [CNT_W-1:0]  cnt_q  [NUM_ZONES];
  logic [CNT_W-1:0]  cnt_d  [NUM_ZONES];
  logic [CNT_W-1:0]  snap_q [NUM_ZONES];

  state_t            state_q;
  state_t            state_d;
  logic              primed_q;
  logic              clr_cnt;
  logic              snap_en;
  logic              scan_en;
  logic              scan_last;
  logic              prime_set;

  logic [ZONE_W-1:0] scan_idx_q;
  logic [ZONE_W-1:0] best_idx_q;
  logic [ZONE_W-1:0] cand_idx;
  logic [CNT_W-1:0]  best_q;
  logic [CNT_W-1:0]  cur;
  logic [CNT_W-1:0]  cand_val;
  logic              cand_found;

  logic [ZONE_W-1:0] zone_q;
  logic              found_q;
  logic              valid_q;
  logic [CNT_W-1:0]  pix_count_q;

  assign clk = hdmi_clk1x_i;
  assign rst = rst_i;

  zone_pixel_classifier #(
    .R_MIN  (R_MIN),
    .GB_MAX (GB_MAX)
  ) u_classifier (
    .clk   (clk),
    .rst   (rst),
    .de    (bus.de),
    .pix_r (bus.pix_r),
    .pix_g (bus.pix_g),
    .pix_b (bus.pix_b),
    .match (match),
    .mask  (bus.mask)
  );

  assign frame_start = (bus.vs == VS_POL) && (vs_d != VS_POL);
  assign line_end    = de_d && !bus.de;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_d <= 1'b0;
      vs_d <= 1'b0;
      x_q  <= '0;
      y_q  <= '0;
    end else begin
      de_d <= bus.de;
      vs_d <= bus.vs;
      if (line_end)    x_q <= '0;
      else if (bus.de) x_q <= x_q + 1'b1;
      if (frame_start)   y_q <= '0;
      else if (line_end) y_q <= y_q + 1'b1;
    end
  end

  // Zone boundaries are fixed, so plain compares replace the divisions.
  always_comb begin
    if (x_q < COL1)      col = 2'd0;
    else if (x_q < COL2) col = 2'd1;
    else if (x_q < COL3) col = 2'd2;
    else                 col = 2'd3;
  end

  assign row      = (y_q >= ROW1);
  assign pix_zone = zone_index(row, col);
  assign in_range = (x_q < H_LIM) && (y_q < V_LIM);
  assign hit      = match && in_range;

  always_comb begin
    for (int z = 0; z < NUM_ZONES; z++) begin
      cnt_d[z] = clr_cnt ? '0 : cnt_q[z];
      if (hit && (pix_zone == ZONE_W'(z)) && (cnt_d[z] != '1))
        cnt_d[z] = cnt_d[z] + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int z = 0; z < NUM_ZONES; z++) begin
        cnt_q[z]  <= '0;
        snap_q[z] <= '0;
      end
    end else begin
      for (int z = 0; z < NUM_ZONES; z++) begin
        cnt_q[z] <= cnt_d[z];
        if (snap_en) snap_q[z] <= cnt_q[z];
      end
    end
  end

  // The first frame start after reset only discards the partial frame.
  always_comb begin
    state_d   = state_q;
    clr_cnt   = 1'b0;
    snap_en   = 1'b0;
    scan_en   = 1'b0;
    scan_last = 1'b0;
    prime_set = 1'b0;
    unique case (state_q)
      ACCUM: begin
        if (frame_start) begin
          if (primed_q) begin
            state_d = SNAP;
          end else begin
            clr_cnt   = 1'b1;
            prime_set = 1'b1;
          end
        end
      end
      SNAP: begin
        snap_en = 1'b1;
        clr_cnt = 1'b1;
        state_d = SCAN;
      end
      SCAN: begin
        if (frame_start) begin
          state_d = SNAP;
        end else begin
          scan_en = 1'b1;
          if (scan_idx_q == LAST_IDX) begin
            scan_last = 1'b1;
            state_d   = ACCUM;
          end
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ACCUM;
      primed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (prime_set) primed_q <= 1'b1;
    end
  end

  // Strict '>' keeps the lowest index on ties.
  assign cur        = snap_q[scan_idx_q];
  assign cand_val   = (cur > best_q) ? cur : best_q;
  assign cand_idx   = (cur > best_q) ? scan_idx_q : best_idx_q;
  assign cand_found = (cand_val >= MIN_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_idx_q  <= '0;
      best_idx_q  <= '0;
      best_q      <= '0;
      zone_q      <= '0;
      found_q     <= 1'b0;
      valid_q     <= 1'b0;
      pix_count_q <= '0;
    end else begin
      valid_q <= 1'b0;
      if (snap_en) begin
        scan_idx_q <= '0;
        best_idx_q <= '0;
        best_q     <= '0;
      end else if (scan_en) begin
        scan_idx_q <= scan_idx_q + 1'b1;
        best_idx_q <= cand_idx;
        best_q     <= cand_val;
      end
      if (scan_last) begin
        pix_count_q <= cand_val;
        found_q     <= cand_found;
        valid_q     <= 1'b1;
        if (cand_found) zone_q <= cand_idx;
      end
    end
  end

  assign bus.zone         = zone_q;
  assign bus.target_found = found_q;
  assign bus.zone_valid   = valid_q;
  assign bus.pix_count    = pix_count_q;
endmodule

// File: tb/tb_zone_detector.sv
// Directed bench for zone_detector on a scaled 32x16 frame (8x8 zones, 6-bit counters).
`timescale 1ns/1ps
module tb_zone_detector;
  import zone_pkg::*;

  localparam int H    = 32;
  localparam int V    = 16;
  localparam int MINP = 10;
  localparam int CW   = 6;

  localparam logic [23:0] RED   = 24'hC81414;
  localparam logic [23:0] WHITE = 24'hFFFFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  zone_detector_if #(.CNT_W(CW)) bus ();

  zone_detector #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .R_MIN      (8'd150),
    .GB_MAX     (8'd80),
    .MIN_PIXELS (MINP),
    .CNT_W      (CW),
    .VS_POL     (1'b1)
  ) dut (
    .hdmi_clk1x_i (clk),
    .rst_i        (rst),
    .bus          (bus)
  );

  int checks   = 0;
  int failures = 0;
  int last_mask_hi;
  int nr;
  int rx0 [4];
  int rx1 [4];
  int ry0 [4];
  int ry1 [4];
  logic [23:0] rc [4];
  logic [23:0] bg;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_pix(input logic d, input logic [23:0] c);
    bus.de    = d;
    bus.pix_r = c[23:16];
    bus.pix_g = c[15:8];
    bus.pix_b = c[7:0];
  endtask

  task automatic clear_rects(input logic [23:0] background);
    nr = 0;
    bg = background;
  endtask

  task automatic add_rect(input int x0, input int x1, input int y0, input int y1, input logic [23:0] c);
    rx0[nr] = x0; rx1[nr] = x1; ry0[nr] = y0; ry1[nr] = y1; rc[nr] = c;
    nr++;
  endtask

  function automatic logic [23:0] colour_at(input int x, input int y);
    logic [23:0] c;
    c = bg;
    for (int i = 0; i < nr; i++)
      if (x >= rx0[i] && x <= rx1[i] && y >= ry0[i] && y <= ry1[i]) c = rc[i];
    return c;
  endfunction

  function automatic logic is_red(input logic [23:0] c);
    return (c[23:16] > 8'd150) && (c[15:8] < 8'd80) && (c[7:0] < 8'd80);
  endfunction

  // Lines of h_len enabled pixels plus 3 blanking cycles; mask is checked every cycle.
  task automatic run_frame(input string tag, input int h_len, input int v_len);
    int mism = 0;
    int hi   = 0;
    logic [23:0] c;
    logic em;
    for (int y = 0; y < v_len; y++) begin
      for (int x = 0; x < h_len + 3; x++) begin
        c  = (x < h_len) ? colour_at(x, y) : 24'h000000;
        em = (x < h_len) && is_red(c);
        drive_pix(x < h_len, c);
        tick();
        if (bus.mask !== em) mism++;
        if (bus.mask === 1'b1) hi++;
      end
    end
    chk({tag, "_mask"}, mism, 0);
    last_mask_hi = hi;
  endtask

  task automatic check_report(input string tag, input bit exp_rep, input logic [2:0] ez,
                              input logic ef, input int ec);
    int pulses = 0;
    int at     = 0;
    bus.vs = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 1) bus.vs = 1'b0;
      if (bus.zone_valid === 1'b1) begin
        pulses++;
        at = k;
      end
    end
    chk({tag, "_pulses"}, pulses, exp_rep ? 1 : 0);
    if (exp_rep) chk({tag, "_latency"}, at, 10);
    chk({tag, "_zone"}, bus.zone, ez);
    chk({tag, "_found"}, bus.target_found, ef);
    chk({tag, "_count"}, bus.pix_count, ec);
  endtask

  initial begin
    int pulses;
    int at;
    bus.vs = 1'b0;
    drive_pix(1'b0, 24'h0);
    clear_rects(24'h0);

    repeat (3) tick();
    chk("rst_mask",  bus.mask, 0);
    chk("rst_zone",  bus.zone, 0);
    chk("rst_found", bus.target_found, 0);
    chk("rst_valid", bus.zone_valid, 0);
    chk("rst_count", bus.pix_count, 0);
    rst = 1'b0;
    repeat (2) tick();

    // Red block in zone 2 over two frames; the partial first frame is discarded.
    clear_rects(24'h0);
    add_rect(18, 21, 2, 4, RED);
    run_frame("blk_f0", H, V);
    check_report("first_fs", 1'b0, 3'd0, 1'b0, 0);
    run_frame("blk_f1", H, V);
    check_report("blk", 1'b1, 3'd2, 1'b1, 12);

    clear_rects(24'h0);
    add_rect(28, 30, 14, 15, RED);
    run_frame("small", H, V);
    check_report("small", 1'b1, 3'd2, 1'b0, 6);

    // Colour thresholds are strict; exactly MIN_PIXELS is accepted.
    clear_rects(24'h0);
    add_rect(16, 23, 0, 7, 24'h961414);
    add_rect(0, 7, 0, 7, 24'h975014);
    add_rect(24, 31, 0, 3, 24'h971450);
    add_rect(0, 4, 8, 9, 24'h974F4F);
    run_frame("thr", H, V);
    check_report("thr", 1'b1, 3'd4, 1'b1, 10);

    clear_rects(24'h0);
    add_rect(8, 12, 8, 10, RED);
    add_rect(19, 23, 12, 14, RED);
    run_frame("tie", H, V);
    check_report("tie", 1'b1, 3'd5, 1'b1, 15);

    clear_rects(WHITE);
    run_frame("white", H, V);
    chk("white_mask_hi", last_mask_hi, 0);
    check_report("white", 1'b1, 3'd5, 1'b0, 0);

    // Second frame start 4 cycles into the scan: only the restarted scan reports.
    clear_rects(24'h0);
    add_rect(8, 11, 0, 2, RED);
    run_frame("abort", H, V);
    pulses = 0;
    bus.vs = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) bus.vs = 1'b0;
      if (bus.zone_valid === 1'b1) pulses++;
    end
    chk("abort_early_pulses", pulses, 0);
    at = 0;
    bus.vs = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 1) bus.vs = 1'b0;
      if (bus.zone_valid === 1'b1) begin
        pulses++;
        at = k;
      end
    end
    chk("abort_pulses", pulses, 1);
    chk("abort_latency", at, 10);
    chk("abort_zone", bus.zone, 5);
    chk("abort_found", bus.target_found, 0);
    chk("abort_count", bus.pix_count, 0);

    // Pixels beyond the active window are ignored.
    clear_rects(24'h0);
    add_rect(0, 3, 0, 2, RED);
    add_rect(32, 35, 0, 17, RED);
    add_rect(0, 31, 16, 17, RED);
    run_frame("oor", H + 4, V + 2);
    check_report("oor", 1'b1, 3'd0, 1'b1, 12);

    clear_rects(24'h0);
    add_rect(24, 31, 0, 7, RED);
    run_frame("sat", H, V);
    check_report("sat", 1'b1, 3'd3, 1'b1, 63);

    // Asynchronous reset in the middle of a red line.
    drive_pix(1'b1, RED);
    repeat (3) tick();
    chk("pre_rst_mask", bus.mask, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_mask",  bus.mask, 0);
    chk("mid_rst_zone",  bus.zone, 0);
    chk("mid_rst_found", bus.target_found, 0);
    chk("mid_rst_count", bus.pix_count, 0);
    drive_pix(1'b0, 24'h0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    check_report("post_rst_fs", 1'b0, 3'd0, 1'b0, 0);
    clear_rects(24'h0);
    add_rect(16, 20, 8, 10, RED);
    run_frame("post_rst", H, V);
    check_report("post_rst", 1'b1, 3'd6, 1'b1, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
